tour_cmd: RTL and testbench
===========================

// Module: tour_cmd
// PURPOSE
//  Consumer end of the TourLogic solution interface. After TourLogic asserts done, this block reads
//  the stored tour one move at a time. It drives the move index and samples the one-hot move.
//  Each knight move becomes two robot commands: a vertical leg, then a horizontal leg.
//  The commands go to the command processor. Outside a tour, UART commands pass straight through.
// PARAMETERS
//  NUM_MOVES   24  moves in a full 5x5 tour (indices 0..NUM_MOVES-1)
//  IDX_W       5   width of mv_indx
// PORTS
//  clk           in   1   system clock
//  rst_n         in   1   asynchronous active-low reset
//  start_tour    in   1   pulse from TourLogic done; begins tour replay
//  move          in   8   one-hot move at mv_indx (combinational read, valid same cycle)
//  mv_indx       out  5   move index presented to TourLogic
//  cmd_UART      in   16  command from UART wrapper
//  cmd_rdy_UART  in   1   UART command valid
//  cmd           out  16  command to command processor
//  cmd_rdy       out  1   cmd valid
//  clr_cmd_rdy   in   1   command processor accepted cmd
//  send_resp     in   1   command processor finished executing cmd
//  resp          out  8   response byte to UART transmitter
// BEHAVIOUR
//  Clock and reset: one clock (clk). Reset (rst_n) is asynchronous, active low.
//  Reset values: state=IDLE, mv_indx=0, cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, resp=8'hA5.
//  Move encoding (dx,dy):
//   b0(+1,+2) b1(-1,+2) b2(-2,+1) b3(-2,-1) b4(-1,-2) b5(+1,-2) b6(+2,-1) b7(+2,+1)
//  Command fields: cmd[15:12] opcode; cmd[11:4] heading; cmd[3:0] squares = |d|.
//   Vertical leg: opcode 4'h2 (move).
//   Horizontal leg: opcode 4'h3 (move with fanfare).
//   Headings: dy>0 8'h00 (N), dy<0 8'h7F (S), dx<0 8'h3F (W), dx>0 8'hBF (E).
//  move is non-one-hot (0 or multiple bits set): cmd = 16'h0000 (no-op). Sequencing continues.
//  FSM, 5 states:
//   IDLE: mux passes UART (cmd=cmd_UART, cmd_rdy=cmd_rdy_UART).
//    start_tour -> mv_indx<=0, go to VERT.
//   VERT: cmd=vertical cmd, cmd_rdy=1.
//    clr_cmd_rdy -> HOLDV. send_resp here is ignored.
//   HOLDV: cmd_rdy=0. send_resp -> HORZ.
//   HORZ: cmd=horizontal cmd, cmd_rdy=1.
//    clr_cmd_rdy -> HOLDH. send_resp here is ignored.
//   HOLDH: cmd_rdy=0.
//    send_resp with mv_indx==NUM_MOVES-1 -> IDLE.
//    send_resp otherwise -> mv_indx++, go to VERT.
//  Decode and cmd_rdy: both combinational from state, move and mv_indx.
//   cmd_rdy rises the cycle after start_tour is sampled.
//   cmd_rdy falls the cycle after clr_cmd_rdy is sampled.
//  UART during a tour: any state other than IDLE ignores cmd_UART and cmd_rdy_UART.
//   cmd_rdy_UART is not buffered; the UART side holds it.
//  start_tour outside IDLE is ignored.
//  resp:
//   8'h5A while in any tour state, except HOLDH with mv_indx==NUM_MOVES-1.
//   8'hA5 in IDLE and on that final HOLDH.
//   The downstream send_resp strobes resp.
//  mv_indx: increments only in HOLDH. Never exceeds NUM_MOVES-1. No wrap.
//  Reset mid-tour: returns to IDLE with mv_indx=0 immediately. No commands are issued after.
// TESTING
//  1. Idle pass-through: cmd_UART=16'h2005, cmd_rdy_UART=1 -> cmd=16'h2005, cmd_rdy=1, resp=8'hA5.
//  2. Single move: start_tour, move=8'h01 at idx0 ->
//     cmd_rdy next cycle, cmd=16'h2002; then cmd=16'h3BF1; mv_indx->1.
//  3. Heading decode: move=8'h08 -> 16'h27F1 then 16'h33F2. Repeat for all 8 one-hot values.
//  4. Full tour: a 24-move model responds to every clr/send_resp ->
//     48 commands issued; final resp=8'hA5; FSM returns to IDLE with mv_indx=23.
//  5. Handshake robustness: send_resp during VERT and start_tour mid-tour are both ignored ->
//     state and mv_indx unchanged; cmd_rdy_UART during tour -> cmd_rdy follows the FSM only.
//  6. Reset mid-tour: assert rst_n=0 in HOLDV at idx 7 ->
//     IDLE, mv_indx=0, cmd_rdy tracks cmd_rdy_UART; a new start_tour restarts at idx 0.

Source files
------------

// File: rtl/tour_cmd.sv
// Replays a stored knight's tour as robot commands: each move becomes a vertical
// leg followed by a horizontal leg. Outside a tour, UART commands pass straight through.
module tour_cmd #(
  parameter int NUM_MOVES = 24,
  parameter int IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  input  logic [15:0]      cmd_UART,
  input  logic             cmd_rdy_UART,
  output logic [15:0]      cmd,
  output logic             cmd_rdy,
  input  logic             clr_cmd_rdy,
  input  logic             send_resp,
  output logic [7:0]       resp
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] VERT  = 3'd1;
  localparam logic [2:0] HOLDV = 3'd2;
  localparam logic [2:0] HORZ  = 3'd3;
  localparam logic [2:0] HOLDH = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic signed [2:0] dx, dy;
  logic              onehot;
  logic              last;
  logic [15:0]       vert_cmd, horz_cmd;

  function automatic logic [3:0] mag(input logic signed [2:0] v);
    mag = (v < 0) ? 4'(-v) : 4'(v);
  endfunction

  // Vertical legs head N/S, horizontal legs head W/E; squares is the leg length.
  function automatic logic [15:0] leg_cmd(input logic [3:0] op,
                                          input logic signed [2:0] d,
                                          input logic vertical);
    logic [7:0] hdg;
    if (vertical) hdg = (d < 0) ? 8'h7F : 8'h00;
    else          hdg = (d < 0) ? 8'h3F : 8'hBF;
    leg_cmd = {op, hdg, mag(d)};
  endfunction

  always_comb begin
    dx     = '0;
    dy     = '0;
    onehot = 1'b1;
    case (move)
      8'h01:   begin dx =  3'sd1; dy =  3'sd2; end
      8'h02:   begin dx = -3'sd1; dy =  3'sd2; end
      8'h04:   begin dx = -3'sd2; dy =  3'sd1; end
      8'h08:   begin dx = -3'sd2; dy = -3'sd1; end
      8'h10:   begin dx = -3'sd1; dy = -3'sd2; end
      8'h20:   begin dx =  3'sd1; dy = -3'sd2; end
      8'h40:   begin dx =  3'sd2; dy = -3'sd1; end
      8'h80:   begin dx =  3'sd2; dy =  3'sd1; end
      default: onehot = 1'b0;
    endcase
  end

  assign vert_cmd = onehot ? leg_cmd(4'h2, dy, 1'b1) : 16'h0000;
  assign horz_cmd = onehot ? leg_cmd(4'h3, dx, 1'b0) : 16'h0000;
  assign last     = (idx_q == IDX_W'(NUM_MOVES - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (start_tour) begin state_d = VERT; idx_d = '0; end
      VERT:  if (clr_cmd_rdy) state_d = HOLDV;
      HOLDV: if (send_resp)   state_d = HORZ;
      HORZ:  if (clr_cmd_rdy) state_d = HOLDH;
      HOLDH: if (send_resp) begin
        if (last) state_d = IDLE;
        else begin
          idx_d   = idx_q + 1'b1;
          state_d = VERT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The final HOLDH already reports A5 so the last response marks tour completion.
  always_comb begin
    cmd     = cmd_UART;
    cmd_rdy = cmd_rdy_UART;
    resp    = 8'hA5;
    case (state_q)
      VERT:    begin cmd = vert_cmd; cmd_rdy = 1'b1; resp = 8'h5A; end
      HOLDV:   begin cmd = vert_cmd; cmd_rdy = 1'b0; resp = 8'h5A; end
      HORZ:    begin cmd = horz_cmd; cmd_rdy = 1'b1; resp = 8'h5A; end
      HOLDH:   begin cmd = horz_cmd; cmd_rdy = 1'b0; resp = last ? 8'hA5 : 8'h5A; end
      default: ;
    endcase
  end

  assign mv_indx = idx_q;

endmodule

// File: tb/tb_tour_cmd.sv
// Directed bench for tour_cmd: move-decode table replayed over a full tour,
// plus pass-through, handshake-robustness and mid-tour reset sequences.
module tb_tour_cmd;
  localparam int NUM_MOVES = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  tour_cmd #(.NUM_MOVES(NUM_MOVES), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move),
    .mv_indx(mv_indx), .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .send_resp(send_resp), .resp(resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] vcmd;
    logic [15:0] hcmd;
  } vec_t;

  vec_t       vecs [10];
  logic [7:0] mv_tab [32];
  int         sel_tab [32];

  // Stored tour: combinational read at the DUT-driven index.
  assign move = mv_tab[mv_indx];

  int   nchecks = 0;
  int   nerrs   = 0;
  int   rises   = 0;
  logic prev_rdy = 1'b0;

  always @(negedge clk) begin
    if (cmd_rdy && !prev_rdy) rises <= rises + 1;
    prev_rdy <= cmd_rdy;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in VERT at index i; leaves after the HOLDH send_resp.
  task automatic run_move(input int i);
    chk($sformatf("vert_rdy[%0d]", i), 16'(cmd_rdy), 16'd1);
    chk($sformatf("vert_idx[%0d]", i), 16'(mv_indx), 16'(i));
    chk($sformatf("vert_cmd[%0d]", i), cmd, vecs[sel_tab[i]].vcmd);
    chk($sformatf("vert_resp[%0d]", i), 16'(resp), 16'h005A);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk($sformatf("holdv_rdy[%0d]", i), 16'(cmd_rdy), 16'd0);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk($sformatf("horz_rdy[%0d]", i), 16'(cmd_rdy), 16'd1);
    chk($sformatf("horz_cmd[%0d]", i), cmd, vecs[sel_tab[i]].hcmd);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk($sformatf("holdh_rdy[%0d]", i), 16'(cmd_rdy), 16'd0);
    chk($sformatf("holdh_resp[%0d]", i), 16'(resp), (i == NUM_MOVES - 1) ? 16'h00A5 : 16'h005A);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
  endtask

  int base;

  initial begin
    vecs[0] = '{8'h01, 16'h2002, 16'h3BF1};
    vecs[1] = '{8'h02, 16'h2002, 16'h33F1};
    vecs[2] = '{8'h04, 16'h2001, 16'h33F2};
    vecs[3] = '{8'h08, 16'h27F1, 16'h33F2};
    vecs[4] = '{8'h10, 16'h27F2, 16'h33F1};
    vecs[5] = '{8'h20, 16'h27F2, 16'h3BF1};
    vecs[6] = '{8'h40, 16'h27F1, 16'h3BF2};
    vecs[7] = '{8'h80, 16'h2001, 16'h3BF2};
    vecs[8] = '{8'h00, 16'h0000, 16'h0000};
    vecs[9] = '{8'h03, 16'h0000, 16'h0000};
    for (int i = 0; i < 32; i++) begin
      sel_tab[i] = i % 10;
      mv_tab[i]  = vecs[i % 10].mv;
    end

    rst_n = 1'b0; start_tour = 1'b0; clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    cmd_UART = 16'h1234; cmd_rdy_UART = 1'b0;
    #1;
    chk("reset_idx", 16'(mv_indx), 16'd0);
    chk("reset_cmd", cmd, 16'h1234);
    chk("reset_rdy", 16'(cmd_rdy), 16'd0);
    chk("reset_resp", 16'(resp), 16'h00A5);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Idle pass-through
    cmd_UART = 16'h2005; cmd_rdy_UART = 1'b1; #1;
    chk("idle_cmd", cmd, 16'h2005);
    chk("idle_rdy", 16'(cmd_rdy), 16'd1);
    chk("idle_resp", 16'(resp), 16'h00A5);
    cmd_rdy_UART = 1'b0; #1;
    chk("idle_rdy_low", 16'(cmd_rdy), 16'd0);

    // Full tour through the decode table
    base = rises;
    start_tour = 1'b1; #1;
    chk("pre_start_rdy", 16'(cmd_rdy), 16'd0);
    tick(); start_tour = 1'b0;
    for (int i = 0; i < NUM_MOVES; i++) run_move(i);
    chk("end_idx", 16'(mv_indx), 16'd23);
    chk("end_rdy", 16'(cmd_rdy), 16'd0);
    chk("end_cmd", cmd, 16'h2005);
    chk("end_resp", 16'(resp), 16'h00A5);
    tick(); tick();
    chk("cmd_count", 16'(rises - base), 16'd48);
    chk("idle_hold_idx", 16'(mv_indx), 16'd23);

    // Handshake robustness
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    chk("ign_sr_rdy", 16'(cmd_rdy), 16'd1);
    chk("ign_sr_cmd", cmd, vecs[0].vcmd);
    chk("ign_sr_idx", 16'(mv_indx), 16'd0);
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("ign_st_rdy", 16'(cmd_rdy), 16'd1);
    chk("ign_st_idx", 16'(mv_indx), 16'd0);
    cmd_UART = 16'hFFFF; cmd_rdy_UART = 1'b1; #1;
    chk("ign_uart_cmd", cmd, vecs[0].vcmd);
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("ign_uart_rdy", 16'(cmd_rdy), 16'd0);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("ign_st_holdh_rdy", 16'(cmd_rdy), 16'd0);
    chk("ign_st_holdh_idx", 16'(mv_indx), 16'd0);
    chk("ign_st_holdh_cmd", cmd, vecs[0].hcmd);
    send_resp = 1'b1; tick(); send_resp = 1'b0;
    for (int i = 1; i < 7; i++) run_move(i);

    // Reset mid-tour in HOLDV at index 7
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    chk("pre_rst_idx", 16'(mv_indx), 16'd7);
    chk("pre_rst_rdy", 16'(cmd_rdy), 16'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_idx", 16'(mv_indx), 16'd0);
    chk("rst_rdy", 16'(cmd_rdy), 16'd1);
    chk("rst_cmd", cmd, 16'hFFFF);
    chk("rst_resp", 16'(resp), 16'h00A5);
    tick();
    rst_n = 1'b1; cmd_rdy_UART = 1'b0;
    tick(); tick();
    send_resp = 1'b1; clr_cmd_rdy = 1'b1; tick(); send_resp = 1'b0; clr_cmd_rdy = 1'b0;
    chk("post_rst_rdy", 16'(cmd_rdy), 16'd0);
    chk("post_rst_idx", 16'(mv_indx), 16'd0);
    start_tour = 1'b1; tick(); start_tour = 1'b0;
    chk("restart_rdy", 16'(cmd_rdy), 16'd1);
    chk("restart_idx", 16'(mv_indx), 16'd0);
    chk("restart_cmd", cmd, vecs[0].vcmd);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
